// File: rtl/cv32e40p_rvfi_retire_sched.sv
// In-order RVFI retirement scheduler: tag allocation, out-of-order completion,
// program-order retirement with order count, interrupt tagging and drain/halt.
module cv32e40p_rvfi_retire_sched #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             alloc_valid_i,
    input  logic [31:0]      alloc_pc_i,
    input  logic [31:0]      alloc_insn_i,
    output logic             alloc_ready_o,
    output logic [PTR_W-1:0] alloc_tag_o,
    input  logic             cmpl_valid_i,
    input  logic [PTR_W-1:0] cmpl_tag_i,
    input  logic [31:0]      cmpl_wdata_i,
    input  logic [13:0]      cmpl_trap_i,
    input  logic             intr_valid_i,
    input  logic [13:0]      intr_i,
    input  logic             halt_req_i,
    input  logic             resume_i,
    output logic             halted_o,
    output logic             rvfi_valid_o,
    output logic [63:0]      rvfi_order_o,
    output logic [31:0]      rvfi_pc_o,
    output logic [31:0]      rvfi_insn_o,
    output logic [31:0]      rvfi_wdata_o,
    output logic [13:0]      rvfi_trap_o,
    output logic [13:0]      rvfi_intr_o,
    output logic             err_o
);

    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] done_q;
    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      insn_q  [DEPTH];
    logic [31:0]      wdata_q [DEPTH];
    logic [13:0]      trap_q  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [63:0]      order_cnt;

    logic             pend_valid_q;
    logic [13:0]      pend_intr_q;

    logic             alloc_fire;
    logic             cmpl_ok;
    logic             cmpl_head;
    logic             retire;
    logic [31:0]      ret_wdata;
    logic [13:0]      ret_trap;

    assign alloc_ready_o = (count_q < CNT_W'(DEPTH)) && (state_q == RUN);
    assign alloc_tag_o   = wr_ptr_q;
    assign halted_o      = (state_q == HALTED);
    assign alloc_fire    = alloc_valid_i & alloc_ready_o;

    assign cmpl_ok   = cmpl_valid_i & busy_q[cmpl_tag_i] & ~done_q[cmpl_tag_i];
    assign cmpl_head = cmpl_ok & (cmpl_tag_i == rd_ptr_q);

    // A completion aimed at the head retires on the same edge (one-cycle latency).
    assign retire = busy_q[rd_ptr_q] & (done_q[rd_ptr_q] | cmpl_head);

    always_comb begin
        ret_wdata = wdata_q[rd_ptr_q];
        ret_trap  = trap_q[rd_ptr_q];
        if (!done_q[rd_ptr_q]) begin
            ret_wdata = cmpl_wdata_i;
            ret_trap  = cmpl_trap_i;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (halt_req_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!halt_req_i) state_d = RUN;
                else if (count_q == '0) state_d = HALTED;
            end
            HALTED: begin
                if (resume_i) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            done_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                insn_q[i]  <= '0;
                wdata_q[i] <= '0;
                trap_q[i]  <= '0;
            end
        end else begin
            if (cmpl_ok) begin
                done_q[cmpl_tag_i]  <= 1'b1;
                wdata_q[cmpl_tag_i] <= cmpl_wdata_i;
                trap_q[cmpl_tag_i]  <= cmpl_trap_i;
            end
            // Placed after the completion update so a bypassed head is freed.
            if (retire) begin
                busy_q[rd_ptr_q] <= 1'b0;
                done_q[rd_ptr_q] <= 1'b0;
            end
            if (alloc_fire) begin
                busy_q[wr_ptr_q] <= 1'b1;
                done_q[wr_ptr_q] <= 1'b0;
                pc_q[wr_ptr_q]   <= alloc_pc_i;
                insn_q[wr_ptr_q] <= alloc_insn_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (alloc_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (retire)     rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({alloc_fire, retire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (cmpl_valid_i && !cmpl_ok) begin
            err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_valid_q <= 1'b0;
            pend_intr_q  <= '0;
        end else if (intr_valid_i) begin
            // A new interrupt stays pending even if an older one is consumed now.
            pend_valid_q <= 1'b1;
            pend_intr_q  <= intr_i;
        end else if (retire) begin
            pend_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvfi_valid_o <= 1'b0;
            rvfi_order_o <= '0;
            rvfi_pc_o    <= '0;
            rvfi_insn_o  <= '0;
            rvfi_wdata_o <= '0;
            rvfi_trap_o  <= '0;
            rvfi_intr_o  <= '0;
            order_cnt    <= '0;
        end else begin
            rvfi_valid_o <= retire;
            if (retire) begin
                rvfi_order_o <= order_cnt;
                rvfi_pc_o    <= pc_q[rd_ptr_q];
                rvfi_insn_o  <= insn_q[rd_ptr_q];
                rvfi_wdata_o <= ret_wdata;
                rvfi_trap_o  <= ret_trap;
                rvfi_intr_o  <= pend_valid_q ? pend_intr_q : 14'd0;
                order_cnt    <= order_cnt + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_rvfi_retire_sched.sv
// Bench for cv32e40p_rvfi_retire_sched: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_cv32e40p_rvfi_retire_sched;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        alloc_valid_i = 1'b0;
    logic [31:0] alloc_pc_i = '0;
    logic [31:0] alloc_insn_i = '0;
    logic        alloc_ready_o;
    logic [1:0]  alloc_tag_o;
    logic        cmpl_valid_i = 1'b0;
    logic [1:0]  cmpl_tag_i = '0;
    logic [31:0] cmpl_wdata_i = '0;
    logic [13:0] cmpl_trap_i = '0;
    logic        intr_valid_i = 1'b0;
    logic [13:0] intr_i = '0;
    logic        halt_req_i = 1'b0;
    logic        resume_i = 1'b0;
    logic        halted_o;
    logic        rvfi_valid_o;
    logic [63:0] rvfi_order_o;
    logic [31:0] rvfi_pc_o;
    logic [31:0] rvfi_insn_o;
    logic [31:0] rvfi_wdata_o;
    logic [13:0] rvfi_trap_o;
    logic [13:0] rvfi_intr_o;
    logic        err_o;

    cv32e40p_rvfi_retire_sched #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .alloc_valid_i(alloc_valid_i), .alloc_pc_i(alloc_pc_i),
        .alloc_insn_i(alloc_insn_i), .alloc_ready_o(alloc_ready_o),
        .alloc_tag_o(alloc_tag_o), .cmpl_valid_i(cmpl_valid_i),
        .cmpl_tag_i(cmpl_tag_i), .cmpl_wdata_i(cmpl_wdata_i),
        .cmpl_trap_i(cmpl_trap_i), .intr_valid_i(intr_valid_i),
        .intr_i(intr_i), .halt_req_i(halt_req_i), .resume_i(resume_i),
        .halted_o(halted_o), .rvfi_valid_o(rvfi_valid_o),
        .rvfi_order_o(rvfi_order_o), .rvfi_pc_o(rvfi_pc_o),
        .rvfi_insn_o(rvfi_insn_o), .rvfi_wdata_o(rvfi_wdata_o),
        .rvfi_trap_o(rvfi_trap_o), .rvfi_intr_o(rvfi_intr_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  tag;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] wdata;
        logic [13:0] trap;
        bit          done;
    } ent_t;

    ent_t        mq[$];
    ent_t        me;
    int          m_tag;
    int          m_st;
    int          m_cnt_pre;
    bit          m_rdy;
    bit          m_found;
    bit          m_err;
    bit          m_pend_v;
    logic [13:0] m_pend;
    logic [63:0] m_order;
    bit          e_valid;
    logic [63:0] e_order;
    logic [31:0] e_pc;
    logic [31:0] e_insn;
    logic [31:0] e_wdata;
    logic [13:0] e_trap;
    logic [13:0] e_intr;

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            mq.delete();
            m_tag = 0; m_st = 0; m_err = 0;
            m_pend_v = 0; m_pend = '0; m_order = '0;
            e_valid = 0; e_order = '0; e_pc = '0; e_insn = '0;
            e_wdata = '0; e_trap = '0; e_intr = '0;
        end else begin
            m_cnt_pre = mq.size();
            m_rdy = (m_cnt_pre < DEPTH) && (m_st == 0);
            if (cmpl_valid_i) begin
                m_found = 0;
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].tag == cmpl_tag_i && !mq[i].done) begin
                        me = mq[i];
                        me.done = 1;
                        me.wdata = cmpl_wdata_i;
                        me.trap = cmpl_trap_i;
                        mq[i] = me;
                        m_found = 1;
                    end
                end
                if (!m_found) m_err = 1;
            end
            e_valid = 0;
            if (mq.size() > 0 && mq[0].done) begin
                me = mq.pop_front();
                e_valid = 1;
                e_order = m_order;
                m_order = m_order + 64'd1;
                e_pc = me.pc; e_insn = me.insn;
                e_wdata = me.wdata; e_trap = me.trap;
                e_intr = m_pend_v ? m_pend : 14'd0;
                m_pend_v = 0;
            end
            if (intr_valid_i) begin
                m_pend = intr_i;
                m_pend_v = 1;
            end
            if (alloc_valid_i && m_rdy) begin
                me.tag = 2'(m_tag); me.pc = alloc_pc_i;
                me.insn = alloc_insn_i; me.done = 0;
                me.wdata = '0; me.trap = '0;
                mq.push_back(me);
                m_tag = (m_tag + 1) % DEPTH;
            end
            case (m_st)
                0: if (halt_req_i) m_st = 1;
                1: if (!halt_req_i) m_st = 0;
                   else if (m_cnt_pre == 0) m_st = 2;
                default: if (resume_i) m_st = 0;
            endcase
            #1;
            chk("m_valid", {63'd0, rvfi_valid_o}, {63'd0, e_valid});
            chk("m_order", rvfi_order_o, e_order);
            chk("m_pc", {32'd0, rvfi_pc_o}, {32'd0, e_pc});
            chk("m_insn", {32'd0, rvfi_insn_o}, {32'd0, e_insn});
            chk("m_wdata", {32'd0, rvfi_wdata_o}, {32'd0, e_wdata});
            chk("m_trap", {50'd0, rvfi_trap_o}, {50'd0, e_trap});
            chk("m_intr", {50'd0, rvfi_intr_o}, {50'd0, e_intr});
            chk("m_ready", {63'd0, alloc_ready_o},
                {63'd0, (mq.size() < DEPTH) && (m_st == 0)});
            chk("m_tag", {62'd0, alloc_tag_o}, 64'(m_tag));
            chk("m_halted", {63'd0, halted_o}, {63'd0, m_st == 2});
            chk("m_err", {63'd0, err_o}, {63'd0, m_err});
        end
    end

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic do_alloc(input logic [31:0] pc);
        alloc_valid_i = 1'b1;
        alloc_pc_i = pc;
        alloc_insn_i = pc ^ 32'h0000_0013;
        @(negedge clk_i);
        alloc_valid_i = 1'b0;
    endtask

    task automatic do_cmpl(input logic [1:0] tag, input logic [31:0] wd);
        cmpl_valid_i = 1'b1;
        cmpl_tag_i = tag;
        cmpl_wdata_i = wd;
        cmpl_trap_i = wd[13:0];
        @(negedge clk_i);
        cmpl_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        chk("rst_ready", {63'd0, alloc_ready_o}, 64'd1);
        chk("rst_valid", {63'd0, rvfi_valid_o}, 64'd0);
        chk("rst_tag", {62'd0, alloc_tag_o}, 64'd0);
        chk("rst_halted", {63'd0, halted_o}, 64'd0);
        chk("rst_err", {63'd0, err_o}, 64'd0);

        // Out-of-order completion retires in program order.
        do_alloc(32'h80);
        do_alloc(32'h84);
        do_cmpl(2'd1, 32'hB0B0);
        chk("t1_hold", {63'd0, rvfi_valid_o}, 64'd0);
        do_cmpl(2'd0, 32'hA0A0);
        chk("t1_a_valid", {63'd0, rvfi_valid_o}, 64'd1);
        chk("t1_a_order", rvfi_order_o, 64'd0);
        chk("t1_a_pc", {32'd0, rvfi_pc_o}, 64'h80);
        chk("t1_a_wdata", {32'd0, rvfi_wdata_o}, 64'hA0A0);
        @(negedge clk_i);
        chk("t1_b_valid", {63'd0, rvfi_valid_o}, 64'd1);
        chk("t1_b_order", rvfi_order_o, 64'd1);
        chk("t1_b_pc", {32'd0, rvfi_pc_o}, 64'h84);
        @(negedge clk_i);
        chk("t1_idle", {63'd0, rvfi_valid_o}, 64'd0);

        // Full queue back-pressure.
        do_alloc(32'h100);
        do_alloc(32'h104);
        do_alloc(32'h108);
        do_alloc(32'h10C);
        chk("t2_full", {63'd0, alloc_ready_o}, 64'd0);
        alloc_valid_i = 1'b1;
        @(negedge clk_i);
        alloc_valid_i = 1'b0;
        do_cmpl(2'd2, 32'h1);
        chk("t2_ret", {63'd0, rvfi_valid_o}, 64'd1);
        chk("t2_ret_pc", {32'd0, rvfi_pc_o}, 64'h100);
        chk("t2_ready", {63'd0, alloc_ready_o}, 64'd1);
        do_cmpl(2'd3, 32'h2);
        do_cmpl(2'd0, 32'h3);
        do_cmpl(2'd1, 32'h4);
        chk("t2_last_order", rvfi_order_o, 64'd5);

        // Duplicate completion flags a sticky error.
        do_alloc(32'h200);
        do_alloc(32'h204);
        do_cmpl(2'd2, 32'h22);
        chk("t3_first", {63'd0, rvfi_valid_o}, 64'd1);
        do_cmpl(2'd2, 32'h33);
        chk("t3_no_extra", {63'd0, rvfi_valid_o}, 64'd0);
        chk("t3_err", {63'd0, err_o}, 64'd1);
        do_cmpl(2'd3, 32'h44);
        chk("t3_err_sticky", {63'd0, err_o}, 64'd1);
        do_alloc(32'h300);
        intr_valid_i = 1'b1;
        intr_i = 14'h3FFF;
        @(negedge clk_i);
        intr_valid_i = 1'b0;
        do_reset();
        chk("t3_rst_err", {63'd0, err_o}, 64'd0);
        chk("t3_rst_order", rvfi_order_o, 64'd0);
        chk("t3_rst_tag", {62'd0, alloc_tag_o}, 64'd0);

        // Interrupt tagging.
        do_alloc(32'h400);
        do_alloc(32'h404);
        intr_valid_i = 1'b1;
        intr_i = {3'b101, 11'd11};
        @(negedge clk_i);
        intr_valid_i = 1'b0;
        do_cmpl(2'd0, 32'h5);
        chk("t4_order", rvfi_order_o, 64'd0);
        chk("t4_cause", {53'd0, rvfi_intr_o[10:0]}, 64'd11);
        do_cmpl(2'd1, 32'h6);
        chk("t4_next", {50'd0, rvfi_intr_o}, 64'd0);
        do_alloc(32'h408);
        intr_valid_i = 1'b1;
        intr_i = {3'b101, 11'd7};
        do_cmpl(2'd2, 32'h7);
        intr_valid_i = 1'b0;
        chk("t4_same_cyc", {50'd0, rvfi_intr_o}, 64'd0);
        do_alloc(32'h40C);
        do_cmpl(2'd3, 32'h8);
        chk("t4_late", {53'd0, rvfi_intr_o[10:0]}, 64'd7);

        // Drain and halt.
        do_alloc(32'h500);
        do_alloc(32'h504);
        do_alloc(32'h508);
        halt_req_i = 1'b1;
        resume_i = 1'b1;
        @(negedge clk_i);
        resume_i = 1'b0;
        chk("t5_blocked", {63'd0, alloc_ready_o}, 64'd0);
        alloc_valid_i = 1'b1;
        @(negedge clk_i);
        alloc_valid_i = 1'b0;
        chk("t5_not_halted", {63'd0, halted_o}, 64'd0);
        do_cmpl(2'd0, 32'h9);
        do_cmpl(2'd1, 32'hA);
        do_cmpl(2'd2, 32'hB);
        chk("t5_last_pc", {32'd0, rvfi_pc_o}, 64'h508);
        for (int i = 0; i < 8 && !halted_o; i++) @(negedge clk_i);
        chk("t5_halted", {63'd0, halted_o}, 64'd1);
        halt_req_i = 1'b0;
        @(negedge clk_i);
        chk("t5_still", {63'd0, halted_o}, 64'd1);
        resume_i = 1'b1;
        @(negedge clk_i);
        resume_i = 1'b0;
        chk("t5_resumed", {63'd0, halted_o}, 64'd0);
        chk("t5_ready", {63'd0, alloc_ready_o}, 64'd1);

        // Order counter wrap.
        force dut.order_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        m_order = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk_i);
        release dut.order_cnt;
        do_alloc(32'h600);
        do_alloc(32'h604);
        do_cmpl(2'd3, 32'hC);
        chk("t6_max", rvfi_order_o, 64'hFFFF_FFFF_FFFF_FFFF);
        do_cmpl(2'd0, 32'hD);
        chk("t6_wrap", rvfi_order_o, 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
